triangle_assembler: RTL and testbench

- Sits directly downstream of the geometry engine and upstream of the rasterizer.
- Accepts screen-space vertices one per handshake and groups every 3 consecutive vertices into a triangle.
- Computes twice the signed area and a screen-clamped integer bounding box for each triangle.
- Culls back-facing, degenerate and fully off-screen triangles; presents survivors to the rasterizer on a valid/ready interface.

---
 rtl/render_pkg.sv | 42 ++++
 rtl/bbox_clamp.sv | 46 ++++
 rtl/triangle_assembler.sv | 212 +++++++++++++++++++++
 tb/tb_triangle_assembler.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/render_pkg.sv
// Shared types and constants for the triangle setup stage.
//   vertex_t    : one screen-space vertex (integer pixel x/y, depth, Q16.16 u/v)
//   tri_t       : an assembled triangle with twice-area and clamped bounding box
//   asm_state_t : triangle assembler FSM states
package render_pkg;

    localparam int          DEF_SCREEN_W = 320;
    localparam int          DEF_SCREEN_H = 240;
    localparam logic [31:0] Q16_ONE      = 32'h00010000;

    // x and y hold two's-complement pixel coordinates; they are stored
    // unsigned here and reinterpreted with $signed where arithmetic needs it.
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  z;
        logic [31:0] u;
        logic [31:0] v;
    } vertex_t;

    typedef struct packed {
        vertex_t [2:0] v;
        logic [34:0]   area2;
        logic [8:0]    bb_xmin;
        logic [8:0]    bb_xmax;
        logic [7:0]    bb_ymin;
        logic [7:0]    bb_ymax;
    } tri_t;

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_AREA    = 2'd1,
        S_CLIP    = 2'd2,
        S_OUTPUT  = 2'd3
    } asm_state_t;

    // Integer pixel part of a Q16.16 coordinate (floor for negatives).
    function automatic logic [15:0] q16_int(input logic [31:0] q);
        return q[31:16];
    endfunction

endpackage

// File: rtl/bbox_clamp.sv
// Bounding-box helper for one screen axis.
//   i_a/i_b/i_c      : the three vertex coordinates (signed pixels)
//   o_min/o_max      : raw min3/max3 of those coordinates
//   i_lo/i_hi        : a previously captured raw min/max to clamp
//   o_lo_clamped/o_hi_clamped : i_lo/i_hi clamped into [0, BOUND-1]
//   o_off_screen     : the span [i_lo, i_hi] lies entirely outside [0, BOUND-1]
// Purely combinational.
module bbox_clamp #(
    parameter int BOUND = 320,
    parameter int OUT_W = 9
) (
    input  logic signed [15:0] i_a,
    input  logic signed [15:0] i_b,
    input  logic signed [15:0] i_c,
    output logic signed [15:0] o_min,
    output logic signed [15:0] o_max,
    input  logic signed [15:0] i_lo,
    input  logic signed [15:0] i_hi,
    output logic [OUT_W-1:0]   o_lo_clamped,
    output logic [OUT_W-1:0]   o_hi_clamped,
    output logic               o_off_screen
);

    function automatic logic [OUT_W-1:0] clamp(input logic signed [15:0] val);
        int v = int'(val);
        if (v < 0) return '0;
        if (v > BOUND - 1) return OUT_W'(BOUND - 1);
        return OUT_W'(v);
    endfunction

    always_comb begin
        o_min = i_a;
        if (i_b < o_min) o_min = i_b;
        if (i_c < o_min) o_min = i_c;
        o_max = i_a;
        if (i_b > o_max) o_max = i_b;
        if (i_c > o_max) o_max = i_c;
    end

    always_comb begin
        o_lo_clamped = clamp(i_lo);
        o_hi_clamped = clamp(i_hi);
        o_off_screen = (i_hi < 16'sd0) || (int'(i_lo) >= BOUND);
    end

endmodule

// File: rtl/triangle_assembler.sv
// Triangle assembler: groups every three accepted vertices into a triangle,
// computes twice the signed area and a screen-clamped bounding box, culls
// back-facing / degenerate / off-screen triangles and hands survivors to the
// rasterizer.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_vertex_valid        vertex present (held by upstream until accepted)
//   o_vertex_ready        vertex accepted on a cycle where valid && ready
//   i_x, i_y              Q16.16 screen coordinates (integer part used)
//   i_z, i_u, i_v         depth and Q16.16 texture coordinates
//   o_tri_valid           triangle presented; held stable until i_tri_ready
//   i_tri_ready           rasterizer takes the triangle on valid && ready
//   o_vx/o_vy/o_vz/o_vu/o_vv  per-vertex outputs, slot order = arrival order
//   o_area2               signed twice-area (positive = front-facing)
//   o_bb_*                clamped bounding box
//   o_cull_count          saturating count of culled triangles
//   o_dbg_state           current FSM state
//
// Handshake: both interfaces transfer on the rising edge where valid and
// ready are both high; a producer holding valid must keep its data stable
// until that edge.
module triangle_assembler
    import render_pkg::*;
#(
    parameter int SCREEN_W      = DEF_SCREEN_W,
    parameter int SCREEN_H      = DEF_SCREEN_H,
    parameter bit CULL_BACKFACE = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_vertex_valid,
    output logic               o_vertex_ready,
    input  logic [31:0]        i_x,
    input  logic [31:0]        i_y,
    input  logic [7:0]         i_z,
    input  logic [31:0]        i_u,
    input  logic [31:0]        i_v,
    output logic               o_tri_valid,
    input  logic               i_tri_ready,
    output logic signed [15:0] o_vx [3],
    output logic signed [15:0] o_vy [3],
    output logic [7:0]         o_vz [3],
    output logic [31:0]        o_vu [3],
    output logic [31:0]        o_vv [3],
    output logic signed [34:0] o_area2,
    output logic [8:0]         o_bb_xmin,
    output logic [8:0]         o_bb_xmax,
    output logic [7:0]         o_bb_ymin,
    output logic [7:0]         o_bb_ymax,
    output logic [15:0]        o_cull_count,
    output asm_state_t         o_dbg_state
);

    asm_state_t         state_q;
    logic [1:0]         idx_q;
    vertex_t            slot_q [3];
    logic               vertex_ready_q;
    logic               tri_valid_q;
    logic [15:0]        cull_count_q;
    logic signed [34:0] area_q;
    logic signed [15:0] xmin_raw_q, xmax_raw_q, ymin_raw_q, ymax_raw_q;
    tri_t               out_q;

    vertex_t in_vertex;
    assign in_vertex = '{x: q16_int(i_x), y: q16_int(i_y), z: i_z, u: i_u, v: i_v};

    // Twice the signed area. Differences need 17 bits, products 34 bits,
    // and the final subtraction one more bit so it can never wrap.
    logic signed [15:0] x0, x1, x2, y0, y1, y2;
    logic signed [16:0] dx1, dy1, dx2, dy2;
    logic signed [33:0] p1, p2;
    logic signed [34:0] area_c;

    always_comb begin
        x0     = $signed(slot_q[0].x);
        x1     = $signed(slot_q[1].x);
        x2     = $signed(slot_q[2].x);
        y0     = $signed(slot_q[0].y);
        y1     = $signed(slot_q[1].y);
        y2     = $signed(slot_q[2].y);
        dx1    = $signed({x1[15], x1}) - $signed({x0[15], x0});
        dy1    = $signed({y1[15], y1}) - $signed({y0[15], y0});
        dx2    = $signed({x2[15], x2}) - $signed({x0[15], x0});
        dy2    = $signed({y2[15], y2}) - $signed({y0[15], y0});
        p1     = 34'(dx1) * 34'(dy2);
        p2     = 34'(dx2) * 34'(dy1);
        area_c = $signed({p1[33], p1}) - $signed({p2[33], p2});
    end

    logic signed [15:0] xmin_c, xmax_c, ymin_c, ymax_c;
    logic [8:0]         xmin_clamped, xmax_clamped;
    logic [7:0]         ymin_clamped, ymax_clamped;
    logic               x_off, y_off;

    bbox_clamp #(.BOUND(SCREEN_W), .OUT_W(9)) u_bbox_x (
        .i_a          (x0),
        .i_b          (x1),
        .i_c          (x2),
        .o_min        (xmin_c),
        .o_max        (xmax_c),
        .i_lo         (xmin_raw_q),
        .i_hi         (xmax_raw_q),
        .o_lo_clamped (xmin_clamped),
        .o_hi_clamped (xmax_clamped),
        .o_off_screen (x_off)
    );

    bbox_clamp #(.BOUND(SCREEN_H), .OUT_W(8)) u_bbox_y (
        .i_a          (y0),
        .i_b          (y1),
        .i_c          (y2),
        .o_min        (ymin_c),
        .o_max        (ymax_c),
        .i_lo         (ymin_raw_q),
        .i_hi         (ymax_raw_q),
        .o_lo_clamped (ymin_clamped),
        .o_hi_clamped (ymax_clamped),
        .o_off_screen (y_off)
    );

    logic face_cull, cull;
    always_comb begin
        face_cull = CULL_BACKFACE ? (area_q <= 35'sd0) : (area_q == 35'sd0);
        cull      = face_cull || x_off || y_off;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= S_COLLECT;
            idx_q          <= 2'd0;
            vertex_ready_q <= 1'b1;
            tri_valid_q    <= 1'b0;
            cull_count_q   <= 16'd0;
            area_q         <= '0;
            xmin_raw_q     <= '0;
            xmax_raw_q     <= '0;
            ymin_raw_q     <= '0;
            ymax_raw_q     <= '0;
            out_q          <= '0;
            for (int i = 0; i < 3; i++) slot_q[i] <= '0;
        end else begin
            unique case (state_q)
                S_COLLECT: begin
                    if (i_vertex_valid && vertex_ready_q) begin
                        slot_q[idx_q] <= in_vertex;
                        if (idx_q == 2'd2) begin
                            idx_q          <= 2'd0;
                            vertex_ready_q <= 1'b0;
                            state_q        <= S_AREA;
                        end else begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end
                end
                S_AREA: begin
                    area_q     <= area_c;
                    xmin_raw_q <= xmin_c;
                    xmax_raw_q <= xmax_c;
                    ymin_raw_q <= ymin_c;
                    ymax_raw_q <= ymax_c;
                    state_q    <= S_CLIP;
                end
                S_CLIP: begin
                    if (cull) begin
                        if (cull_count_q != 16'hFFFF) cull_count_q <= cull_count_q + 16'd1;
                        vertex_ready_q <= 1'b1;
                        state_q        <= S_COLLECT;
                    end else begin
                        for (int i = 0; i < 3; i++) out_q.v[i] <= slot_q[i];
                        out_q.area2   <= area_q;
                        out_q.bb_xmin <= xmin_clamped;
                        out_q.bb_xmax <= xmax_clamped;
                        out_q.bb_ymin <= ymin_clamped;
                        out_q.bb_ymax <= ymax_clamped;
                        tri_valid_q   <= 1'b1;
                        state_q       <= S_OUTPUT;
                    end
                end
                S_OUTPUT: begin
                    if (i_tri_ready) begin
                        tri_valid_q    <= 1'b0;
                        vertex_ready_q <= 1'b1;
                        state_q        <= S_COLLECT;
                    end
                end
                default: state_q <= S_COLLECT;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            o_vx[i] = $signed(out_q.v[i].x);
            o_vy[i] = $signed(out_q.v[i].y);
            o_vz[i] = out_q.v[i].z;
            o_vu[i] = out_q.v[i].u;
            o_vv[i] = out_q.v[i].v;
        end
    end

    assign o_vertex_ready = vertex_ready_q;
    assign o_tri_valid    = tri_valid_q;
    assign o_area2        = $signed(out_q.area2);
    assign o_bb_xmin      = out_q.bb_xmin;
    assign o_bb_xmax      = out_q.bb_xmax;
    assign o_bb_ymin      = out_q.bb_ymin;
    assign o_bb_ymax      = out_q.bb_ymax;
    assign o_cull_count   = cull_count_q;
    assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_triangle_assembler.sv
// Directed bench for triangle_assembler. Instance A culls back faces,
// instance B only culls zero-area triangles. Expected triangles are queued
// when stimulus is issued and popped by per-instance monitors.
module tb_triangle_assembler;
    import render_pkg::*;

    localparam int EW = 381;

    // ---------------- clock / reset ----------------
    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    // ---------------- DUT signals ----------------
    logic [31:0] d_x, d_y, d_u, d_v;
    logic [7:0]  d_z;
    logic valid_a, valid_b, ready_a, ready_b;
    logic tri_valid_a, tri_valid_b, tri_ready_a, tri_ready_b;
    logic signed [15:0] vx_a [3], vy_a [3], vx_b [3], vy_b [3];
    logic [7:0]  vz_a [3], vz_b [3];
    logic [31:0] vu_a [3], vv_a [3], vu_b [3], vv_b [3];
    logic signed [34:0] area_a, area_b;
    logic [8:0]  xmin_a, xmax_a, xmin_b, xmax_b;
    logic [7:0]  ymin_a, ymax_a, ymin_b, ymax_b;
    logic [15:0] cull_a, cull_b;
    asm_state_t  st_a, st_b;

    triangle_assembler #(.SCREEN_W(320), .SCREEN_H(240), .CULL_BACKFACE(1'b1)) dut_a (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_vertex_valid(valid_a), .o_vertex_ready(ready_a),
        .i_x(d_x), .i_y(d_y), .i_z(d_z), .i_u(d_u), .i_v(d_v),
        .o_tri_valid(tri_valid_a), .i_tri_ready(tri_ready_a),
        .o_vx(vx_a), .o_vy(vy_a), .o_vz(vz_a), .o_vu(vu_a), .o_vv(vv_a),
        .o_area2(area_a),
        .o_bb_xmin(xmin_a), .o_bb_xmax(xmax_a), .o_bb_ymin(ymin_a), .o_bb_ymax(ymax_a),
        .o_cull_count(cull_a), .o_dbg_state(st_a)
    );

    triangle_assembler #(.SCREEN_W(320), .SCREEN_H(240), .CULL_BACKFACE(1'b0)) dut_b (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_vertex_valid(valid_b), .o_vertex_ready(ready_b),
        .i_x(d_x), .i_y(d_y), .i_z(d_z), .i_u(d_u), .i_v(d_v),
        .o_tri_valid(tri_valid_b), .i_tri_ready(tri_ready_b),
        .o_vx(vx_b), .o_vy(vy_b), .o_vz(vz_b), .o_vu(vu_b), .o_vv(vv_b),
        .o_area2(area_b),
        .o_bb_xmin(xmin_b), .o_bb_xmax(xmax_b), .o_bb_ymin(ymin_b), .o_bb_ymax(ymax_b),
        .o_cull_count(cull_b), .o_dbg_state(st_b)
    );

    logic [EW-1:0] act_a, act_b;
    assign act_a = {area_a, xmin_a, xmax_a, ymin_a, ymax_a,
                    vx_a[0], vx_a[1], vx_a[2], vy_a[0], vy_a[1], vy_a[2],
                    vz_a[0], vz_a[1], vz_a[2], vu_a[0], vu_a[1], vu_a[2],
                    vv_a[0], vv_a[1], vv_a[2]};
    assign act_b = {area_b, xmin_b, xmax_b, ymin_b, ymax_b,
                    vx_b[0], vx_b[1], vx_b[2], vy_b[0], vy_b[1], vy_b[2],
                    vz_b[0], vz_b[1], vz_b[2], vu_b[0], vu_b[1], vu_b[2],
                    vv_b[0], vv_b[1], vv_b[2]};

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_a_q [$];
    logic [EW-1:0] exp_b_q [$];
    int checks = 0;
    int errors = 0;

    logic [15:0] sx [3], sy [3];
    logic [7:0]  sz [3];
    logic [31:0] su [3], sv [3];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_vertex(input int k, input int x, input int y);
        d_x = {16'(x), 16'h4321};
        d_y = {16'(y), 16'h0FF0};
        d_z = 8'(64 + k * 17 + x);
        d_u = 32'(x * 1000 + k);
        d_v = {16'(y), 8'(k), 8'h5A};
        sx[k] = 16'(x);
        sy[k] = 16'(y);
        sz[k] = d_z;
        su[k] = d_u;
        sv[k] = d_v;
    endtask

    task automatic send_vertex(input bit which, input int k, input int x, input int y);
        int n = 0;
        set_vertex(k, x, y);
        if (which) valid_b = 1'b1; else valid_a = 1'b1;
        while (!(which ? ready_b : ready_a) && n < 100) begin
            @(posedge i_clk); #1;
            n++;
        end
        check("vertex_accept_timeout", 64'(n < 100), 64'd1);
        @(posedge i_clk); #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    task automatic send_tri(input bit which, input int ax, input int ay,
                            input int bx, input int by, input int cx, input int cy);
        send_vertex(which, 0, ax, ay);
        send_vertex(which, 1, bx, by);
        send_vertex(which, 2, cx, cy);
    endtask

    task automatic push_exp(input bit which, input int area, input int xmin, input int xmax,
                            input int ymin, input int ymax);
        logic [EW-1:0] e;
        e = {35'(area), 9'(xmin), 9'(xmax), 8'(ymin), 8'(ymax),
             sx[0], sx[1], sx[2], sy[0], sy[1], sy[2], sz[0], sz[1], sz[2],
             su[0], su[1], su[2], sv[0], sv[1], sv[2]};
        if (which) exp_b_q.push_back(e); else exp_a_q.push_back(e);
    endtask

    task automatic wait_ready(input bit which);
        int n = 0;
        while (!(which ? ready_b : ready_a) && n < 100) begin
            @(posedge i_clk); #1;
            n++;
        end
        check("idle_timeout", 64'(n < 100), 64'd1);
    endtask

    task automatic report_tri(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] e);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: area got %0d expected %0d; fields got %h expected %h",
                     tag, $signed(got[EW-1 -: 35]), $signed(e[EW-1 -: 35]), got, e);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge i_clk) begin
        if (!i_rst && tri_valid_a && tri_ready_a) begin
            if (exp_a_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tri_a_unexpected: got area %0d expected no triangle", area_a);
            end else begin
                report_tri("tri_a", act_a, exp_a_q.pop_front());
            end
        end
        if (!i_rst && tri_valid_b && tri_ready_b) begin
            if (exp_b_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tri_b_unexpected: got area %0d expected no triangle", area_b);
            end else begin
                report_tri("tri_b", act_b, exp_b_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        i_rst = 1'b1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        tri_ready_a = 1'b1;
        tri_ready_b = 1'b1;
        d_x = '0; d_y = '0; d_z = '0; d_u = '0; d_v = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_vertex_ready", 64'(ready_a), 64'd1);
        check("rst_tri_valid", 64'(tri_valid_a), 64'd0);
        check("rst_cull_count", 64'(cull_a), 64'd0);
        check("rst_area", 64'(area_a), 64'd0);
        check("rst_bbox", 64'({xmin_a, xmax_a, ymin_a, ymax_a}), 64'd0);
        i_rst = 1'b0;

        // 1. front-facing triangle, latency of two cycles after third accept
        send_tri(1'b0, 10, 10, 50, 10, 10, 40);
        push_exp(1'b0, 1200, 10, 50, 10, 40);
        check("lat_n", 64'(tri_valid_a), 64'd0);
        @(posedge i_clk); #1;
        check("lat_n1", 64'(tri_valid_a), 64'd0);
        @(posedge i_clk); #1;
        check("lat_n2", 64'(tri_valid_a), 64'd1);
        wait_ready(1'b0);

        // 2. back face: culled in A, emitted with negative area in B
        send_tri(1'b0, 10, 10, 10, 40, 50, 10);
        wait_ready(1'b0);
        check("backface_cull_count", 64'(cull_a), 64'd1);
        send_tri(1'b1, 10, 10, 10, 40, 50, 10);
        push_exp(1'b1, -1200, 10, 50, 10, 40);
        wait_ready(1'b1);
        check("b_cull_count", 64'(cull_b), 64'd0);

        // 3. degenerate and fully off-screen
        send_tri(1'b0, 0, 0, 5, 5, 10, 10);
        wait_ready(1'b0);
        send_tri(1'b0, -50, -50, -10, -50, -50, -10);
        wait_ready(1'b0);
        check("degen_offscreen_cull_count", 64'(cull_a), 64'd3);

        // 4. clamping to the screen edge
        send_tri(1'b0, 300, 200, 400, 200, 300, 300);
        push_exp(1'b0, 10000, 300, 319, 200, 239);
        wait_ready(1'b0);

        // 5. backpressure: outputs hold, a presented vertex is not consumed
        tri_ready_a = 1'b0;
        send_tri(1'b0, 20, 20, 60, 20, 20, 60);
        push_exp(1'b0, 1600, 20, 60, 20, 60);
        @(posedge i_clk); #1;
        set_vertex(0, 100, 100);
        valid_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clk); #1;
            check("stall_tri_valid", 64'(tri_valid_a), 64'd1);
            check("stall_vertex_ready", 64'(ready_a), 64'd0);
            checks++;
            if (exp_a_q.size() == 0 || act_a !== exp_a_q[0]) begin
                errors++;
                $display("FAIL stall_outputs_stable: got area %0d expected 1600", area_a);
            end
        end
        tri_ready_a = 1'b1;
        send_tri(1'b0, 100, 100, 140, 100, 100, 140);
        push_exp(1'b0, 1600, 100, 140, 100, 140);
        wait_ready(1'b0);
        check("post_stall_cull_count", 64'(cull_a), 64'd3);

        // 6. reset mid-collect discards the partial triangle
        send_vertex(1'b0, 0, 0, 0);
        send_vertex(1'b0, 1, 200, 0);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        check("midrst_cull_count", 64'(cull_a), 64'd0);
        check("midrst_tri_valid", 64'(tri_valid_a), 64'd0);
        check("midrst_vertex_ready", 64'(ready_a), 64'd1);
        send_tri(1'b0, 30, 30, 80, 30, 30, 90);
        push_exp(1'b0, 3000, 30, 80, 30, 90);
        wait_ready(1'b0);

        // drain
        n = 0;
        while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && n < 50) begin
            @(posedge i_clk); #1;
            n++;
        end
        check("drain_a", 64'(exp_a_q.size()), 64'd0);
        check("drain_b", 64'(exp_b_q.size()), 64'd0);
        check("final_cull_count", 64'(cull_a), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
